// File: rtl/sc_frame_responder_if.sv
// Signal bundle between the slow-control frame responder and its command FIFO,
// register bus, response FIFO and status outputs.
interface sc_frame_responder_if;
    logic [63:0] fifo_do;
    logic        fifo_empty;
    logic        fifo_rden;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_wr;
    logic        reg_rd;
    logic [7:0]  reg_rdata;
    logic        reg_ack;
    logic [63:0] rsp_di;
    logic        rsp_wren;
    logic        rsp_full;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    modport master (
        input  fifo_do, fifo_empty, reg_rdata, reg_ack, rsp_full,
        output fifo_rden, reg_addr, reg_wdata, reg_wr, reg_rd,
               rsp_di, rsp_wren, busy, frame_cnt, err_cnt
    );

    modport slave (
        output fifo_do, fifo_empty, reg_rdata, reg_ack, rsp_full,
        input  fifo_rden, reg_addr, reg_wdata, reg_wr, reg_rd,
               rsp_di, rsp_wren, busy, frame_cnt, err_cnt
    );
endinterface

// File: rtl/sc_frame_responder.sv
// Slow-control frame responder: pops 64-bit command frames, performs register
// bus reads/writes (bursts for reads) and emits one response word per access.
module sc_frame_responder #(
    parameter logic [7:0] HEADER    = 8'h7E,
    parameter logic [6:0] GBTX_ADDR = 7'h01,
    parameter int         TIMEOUT   = 255
) (
    input logic                  clk,
    input logic                  reset,
    sc_frame_responder_if.master bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LATCH  = 3'd2,
        DECODE = 3'd3,
        BUS    = 3'd4,
        RESP   = 3'd5
    } state_t;

    localparam logic [15:0] TOUT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [63:0] frame_q, frame_d;
    logic [15:0] index_q, index_d;
    logic [15:0] count_q, count_d;
    logic [15:0] timer_q, timer_d;
    logic [7:0]  data_q, data_d;
    logic        hdr_err_q, hdr_err_d;
    logic        tout_q, tout_d;
    logic        err_seen_q, err_seen_d;

    logic        fifo_rden_q, fifo_rden_d;
    logic [15:0] reg_addr_q, reg_addr_d;
    logic [7:0]  reg_wdata_q, reg_wdata_d;
    logic        reg_wr_q, reg_wr_d;
    logic        reg_rd_q, reg_rd_d;
    logic [63:0] rsp_di_q, rsp_di_d;
    logic        rsp_wren_q, rsp_wren_d;
    logic        busy_q, busy_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic [7:0]  f_hdr;
    logic [6:0]  f_addr;
    logic        f_rw;
    logic [15:0] f_nb;
    logic [15:0] f_raddr;
    logic [7:0]  f_wdata;
    logic [7:0]  f_mask;
    logic [16:0] addr_sum_s;
    logic [7:0]  status_raw_s;
    logic [7:0]  status_rep_s;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'h01;
    endfunction

    assign f_hdr   = frame_q[63:56];
    assign f_addr  = frame_q[55:49];
    assign f_rw    = frame_q[48];
    assign f_nb    = frame_q[47:32];
    assign f_raddr = frame_q[31:16];
    assign f_wdata = frame_q[15:8];
    assign f_mask  = frame_q[7:0];

    // Carry out of the 17-bit sum flags a burst that wrapped past 16'hFFFF.
    assign addr_sum_s   = {1'b0, f_raddr} + {1'b0, index_q};
    assign status_raw_s = {4'h0, addr_sum_s[16], tout_q, 1'b0, hdr_err_q};
    assign status_rep_s = status_raw_s & ~(f_mask & 8'hFE);

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            frame_q     <= 64'h0;
            index_q     <= 16'h0;
            count_q     <= 16'h0;
            timer_q     <= 16'h0;
            data_q      <= 8'h0;
            hdr_err_q   <= 1'b0;
            tout_q      <= 1'b0;
            err_seen_q  <= 1'b0;
            fifo_rden_q <= 1'b0;
            reg_addr_q  <= 16'h0;
            reg_wdata_q <= 8'h0;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            rsp_di_q    <= 64'h0;
            rsp_wren_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= 16'h0;
            err_cnt_q   <= 8'h0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            index_q     <= index_d;
            count_q     <= count_d;
            timer_q     <= timer_d;
            data_q      <= data_d;
            hdr_err_q   <= hdr_err_d;
            tout_q      <= tout_d;
            err_seen_q  <= err_seen_d;
            fifo_rden_q <= fifo_rden_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_wr_q    <= reg_wr_d;
            reg_rd_q    <= reg_rd_d;
            rsp_di_q    <= rsp_di_d;
            rsp_wren_q  <= rsp_wren_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        index_d     = index_q;
        count_d     = count_q;
        timer_d     = timer_q;
        data_d      = data_q;
        hdr_err_d   = hdr_err_q;
        tout_d      = tout_q;
        err_seen_d  = err_seen_q;
        fifo_rden_d = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_wr_d    = reg_wr_q;
        reg_rd_d    = reg_rd_q;
        rsp_di_d    = rsp_di_q;
        rsp_wren_d  = 1'b0;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;

        case (state_q)
            IDLE: begin
                if (!bus.fifo_empty) begin
                    fifo_rden_d = 1'b1;
                    state_d     = POP;
                end else begin
                    state_d = IDLE;
                end
            end
            POP: begin
                state_d = LATCH;
            end
            LATCH: begin
                frame_d = bus.fifo_do;
                state_d = DECODE;
            end
            DECODE: begin
                index_d    = 16'h0;
                timer_d    = 16'h0;
                tout_d     = 1'b0;
                err_seen_d = 1'b0;
                hdr_err_d  = 1'b0;
                data_d     = f_rw ? 8'h00 : f_wdata;
                count_d    = f_rw ? ((f_nb == 16'h0) ? 16'h1 : f_nb) : 16'h1;
                if (f_hdr != HEADER) begin
                    hdr_err_d = 1'b1;
                    count_d   = 16'h1;
                    state_d   = RESP;
                end else if (f_addr != GBTX_ADDR) begin
                    err_cnt_d = sat_inc8(err_cnt_q);
                    state_d   = IDLE;
                end else begin
                    frame_cnt_d = frame_cnt_q + 16'h1;
                    state_d     = BUS;
                end
            end
            BUS: begin
                // The first BUS cycle only launches the strobe; ack is honoured afterwards.
                if (!reg_wr_q && !reg_rd_q) begin
                    reg_addr_d  = addr_sum_s[15:0];
                    reg_wdata_d = f_rw ? reg_wdata_q : f_wdata;
                    reg_wr_d    = ~f_rw;
                    reg_rd_d    = f_rw;
                    timer_d     = 16'h0;
                end else if (bus.reg_ack) begin
                    reg_wr_d = 1'b0;
                    reg_rd_d = 1'b0;
                    data_d   = f_rw ? bus.reg_rdata : f_wdata;
                    state_d  = RESP;
                end else if (timer_q == TOUT_LAST) begin
                    reg_wr_d = 1'b0;
                    reg_rd_d = 1'b0;
                    data_d   = 8'h00;
                    tout_d   = 1'b1;
                    state_d  = RESP;
                end else begin
                    timer_d = timer_q + 16'h1;
                end
            end
            RESP: begin
                if (bus.rsp_full) begin
                    state_d = RESP;
                end else begin
                    rsp_wren_d = 1'b1;
                    rsp_di_d   = {HEADER, GBTX_ADDR, f_rw, index_q, addr_sum_s[15:0],
                                  data_q, status_rep_s};
                    if ((status_rep_s != 8'h00) && !err_seen_q) begin
                        err_cnt_d  = sat_inc8(err_cnt_q);
                        err_seen_d = 1'b1;
                    end else begin
                        err_seen_d = err_seen_q;
                    end
                    index_d = index_q + 16'h1;
                    if (((index_q + 16'h1) < count_q) && !tout_q && !hdr_err_q) begin
                        state_d = BUS;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.fifo_rden = fifo_rden_q;
    assign bus.reg_addr  = reg_addr_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign bus.reg_wr    = reg_wr_q;
    assign bus.reg_rd    = reg_rd_q;
    assign bus.rsp_di    = rsp_di_q;
    assign bus.rsp_wren  = rsp_wren_q;
    assign bus.busy      = busy_q;
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule
